// File: rtl/fsm_stim_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fsm_stim_arbiter
// Brief    : Round-robin stimulus arbiter (host / BIST) for a shared benchmark
//            FSM, with a per-request hold count and an output-stall watchdog.
// Revision : 1.0  initial release
// ============================================================================
module fsm_stim_arbiter #(
    parameter int XW          = 5,
    parameter int YW          = 25,
    parameter int HOLDW       = 4,
    parameter int STALL_LIMIT = 8,
    parameter int STALLW      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [XW-1:0]     req0_x,
    input  logic [HOLDW-1:0]  req0_hold,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [XW-1:0]     req1_x,
    input  logic [HOLDW-1:0]  req1_hold,
    output logic [XW-1:0]     dut_x,
    output logic              dut_apply,
    input  logic [YW-1:0]     dut_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [YW-1:0]     rsp_y,
    output logic              rsp_stall,
    output logic              stall_flag,
    input  logic              stall_clr
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_APPLY   = 2'd1,
        ST_RESPOND = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    state_t              state_q,      state_d;
    logic                last_grant_q, last_grant_d;
    logic                id_q,         id_d;
    logic [XW-1:0]       x_q,          x_d;
    logic [HOLDW-1:0]    hold_cnt_q,   hold_cnt_d;
    logic [STALLW-1:0]   stall_cnt_q,  stall_cnt_d;
    logic [YW-1:0]       prev_y_q,     prev_y_d;
    logic [YW-1:0]       rsp_y_q,      rsp_y_d;
    logic                rsp_stall_q,  rsp_stall_d;
    logic                stall_flag_q, stall_flag_d;

    logic                w_pick1;
    logic [HOLDW-1:0]    w_hold_sel;
    logic [STALLW-1:0]   w_stall_inc;
    logic [STALLW-1:0]   w_stall_nxt;

    // BIST wins only when the host is absent or the host had the last grant.
    assign w_pick1     = req1_valid && (!req0_valid || (last_grant_q == 1'b0));
    assign w_hold_sel  = w_pick1 ? req1_hold : req0_hold;
    assign w_stall_inc = (stall_cnt_q == {STALLW{1'b1}}) ? stall_cnt_q
                                                         : stall_cnt_q + STALLW'(1);
    assign w_stall_nxt = (dut_y == prev_y_q) ? w_stall_inc : '0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        x_d          = x_q;
        hold_cnt_d   = hold_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        prev_y_d     = prev_y_q;
        rsp_y_d      = rsp_y_q;
        rsp_stall_d  = rsp_stall_q;
        stall_flag_d = stall_flag_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        dut_apply    = 1'b0;
        dut_x        = x_q;
        rsp_valid    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready   = !w_pick1;
                    req1_ready   = w_pick1;
                    id_d         = w_pick1;
                    last_grant_d = w_pick1;
                    x_d          = w_pick1 ? req1_x : req0_x;
                    hold_cnt_d   = (w_hold_sel == '0) ? HOLDW'(1) : w_hold_sel;
                    state_d      = ST_APPLY;
                end
            end
            ST_APPLY: begin
                dut_apply   = 1'b1;
                stall_cnt_d = w_stall_nxt;
                prev_y_d    = dut_y;
                // A watchdog abort outranks a normal end in the same cycle.
                if (w_stall_nxt >= STALLW'(STALL_LIMIT)) begin
                    rsp_y_d      = dut_y;
                    rsp_stall_d  = 1'b1;
                    stall_flag_d = 1'b1;
                    state_d      = ST_RESPOND;
                end else if (hold_cnt_q == HOLDW'(1)) begin
                    rsp_y_d     = dut_y;
                    rsp_stall_d = 1'b0;
                    state_d     = ST_RESPOND;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLDW'(1);
                end
            end
            ST_RESPOND: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = rsp_stall_q ? ST_LOCKED : ST_IDLE;
                end
            end
            ST_LOCKED: begin
                dut_x = '0;
                if (stall_clr) begin
                    stall_flag_d = 1'b0;
                    stall_cnt_d  = '0;
                    prev_y_d     = '0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            x_q          <= '0;
            hold_cnt_q   <= '0;
            stall_cnt_q  <= '0;
            prev_y_q     <= '0;
            rsp_y_q      <= '0;
            rsp_stall_q  <= 1'b0;
            stall_flag_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            x_q          <= x_d;
            hold_cnt_q   <= hold_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            prev_y_q     <= prev_y_d;
            rsp_y_q      <= rsp_y_d;
            rsp_stall_q  <= rsp_stall_d;
            stall_flag_q <= stall_flag_d;
        end
    end

    assign rsp_id     = id_q;
    assign rsp_y      = rsp_y_q;
    assign rsp_stall  = rsp_stall_q;
    assign stall_flag = stall_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_stim_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fsm_stim_arbiter
// Brief    : Directed + randomized bench for fsm_stim_arbiter with a simple
//            counting stand-in for the benchmark FSM and a transaction model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fsm_stim_arbiter;

    localparam int XW          = 5;
    localparam int YW          = 25;
    localparam int HOLDW       = 4;
    localparam int STALL_LIMIT = 8;
    localparam int STALLW      = 4;
    localparam logic [YW-1:0] TRAP_Y = 25'h0ABCDE;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [XW-1:0]     req0_x, req1_x, dut_x;
    logic [HOLDW-1:0]  req0_hold, req1_hold;
    logic              dut_apply, rsp_valid, rsp_ready, rsp_id, rsp_stall;
    logic [YW-1:0]     dut_y, rsp_y;
    logic              stall_flag, stall_clr;
    logic              trap;
    logic [11:0]       s;

    always #5 clk = ~clk;

    // Stand-in FSM: a step counter visible in the outputs, or a frozen trap word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            s <= '0;
        else if (dut_apply) s <= s + 12'd1;
    end
    assign dut_y = trap ? TRAP_Y : {s, 8'hA5, dut_x};

    fsm_stim_arbiter #(
        .XW(XW), .YW(YW), .HOLDW(HOLDW), .STALL_LIMIT(STALL_LIMIT), .STALLW(STALLW)
    ) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_hold(req0_hold),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_hold(req1_hold),
        .dut_x(dut_x), .dut_apply(dut_apply), .dut_y(dut_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .rsp_stall(rsp_stall), .stall_flag(stall_flag), .stall_clr(stall_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int           m_left;    // apply cycles still owed to the current request
    bit           m_resp;    // a response is waiting to be consumed
    bit           m_locked;
    bit           m_last, m_id, m_flag, m_rs;
    logic [XW-1:0] m_x;
    logic [YW-1:0] m_prev, m_ry;
    int           m_run;
    bit           m_idle, e_r0, e_r1;
    int           m_h;

    always @(negedge clk) begin
        if (rst) begin
            m_left = 0; m_resp = 0; m_locked = 0; m_last = 1; m_id = 0; m_flag = 0;
            m_rs = 0; m_x = '0; m_prev = '0; m_ry = '0; m_run = 0;
        end
        m_idle = (m_left == 0) && !m_resp && !m_locked;
        e_r0   = m_idle && req0_valid && (!req1_valid || m_last);
        e_r1   = m_idle && req1_valid && (!req0_valid || !m_last);
        chk("req0_ready", req0_ready, e_r0);
        chk("req1_ready", req1_ready, e_r1);
        chk("dut_apply",  dut_apply,  m_left > 0);
        chk("rsp_valid",  rsp_valid,  m_resp);
        chk("stall_flag", stall_flag, m_flag);
        if (m_left > 0 || m_resp)  chk("dut_x", dut_x, m_x);
        if (m_locked || rst)       chk("dut_x_zero", dut_x, 0);
        if (m_resp || rst) begin
            chk("rsp_id",    rsp_id,    m_id);
            chk("rsp_y",     rsp_y,     m_ry);
            chk("rsp_stall", rsp_stall, m_rs);
        end
        if (!rst) begin
            if (e_r0 || e_r1) begin
                m_id   = e_r1;
                m_last = e_r1;
                m_x    = e_r1 ? req1_x : req0_x;
                m_h    = e_r1 ? int'(req1_hold) : int'(req0_hold);
                m_left = (m_h == 0) ? 1 : m_h;
            end else if (m_left > 0) begin
                if (dut_y == m_prev) m_run = (m_run < (1 << STALLW) - 1) ? m_run + 1 : m_run;
                else                 m_run = 0;
                m_prev = dut_y;
                if (m_run >= STALL_LIMIT) begin
                    m_ry = dut_y; m_rs = 1; m_flag = 1; m_left = 0; m_resp = 1;
                end else if (m_left == 1) begin
                    m_ry = dut_y; m_rs = 0; m_left = 0; m_resp = 1;
                end else begin
                    m_left--;
                end
            end else if (m_resp) begin
                if (rsp_ready) begin
                    m_resp   = 0;
                    m_locked = m_rs;
                end
            end else if (m_locked && stall_clr) begin
                m_locked = 0; m_flag = 0; m_run = 0; m_prev = '0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req0_valid = 0; req1_valid = 0; stall_clr = 0; trap = 0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Issue one request, wait for its grant, then for its response (bounded).
    task automatic serve(input bit id, input logic [XW-1:0] x, input logic [HOLDW-1:0] hold,
                         output int applies, output int lat, output logic [YW-1:0] y,
                         output logic rid, output logic stl);
        bit got;
        applies = 0; lat = 0; y = '0; rid = 0; stl = 0;
        if (id) begin req1_valid = 1; req1_x = x; req1_hold = hold; end
        else    begin req0_valid = 1; req0_x = x; req0_hold = hold; end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) === 1'b1) got = 1;
            else tick();
        end
        chk("serve_grant", got, 1);
        tick();
        req0_valid = 0; req1_valid = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (dut_apply) applies++;
            if (rsp_valid) begin
                got = 1; y = rsp_y; rid = rsp_id; stl = rsp_stall;
            end else begin
                tick();
            end
        end
        chk("serve_rsp", got, 1);
    endtask

    int           ap, lt;
    logic [YW-1:0] ry, ry0;
    logic         rid, rst_l;
    bit           gl[$];
    bit           got;

    initial begin
        rst = 1'b1; trap = 0; stall_clr = 0; rsp_ready = 0;
        req0_valid = 0; req1_valid = 0; req0_x = '0; req1_x = '0; req0_hold = '0; req1_hold = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: single host request, hold 3
        rsp_ready = 1;
        serve(0, 5'b11001, 4'd3, ap, lt, ry, rid, rst_l);
        chk("t1_applies", ap, 3);
        chk("t1_latency", lt, 4);
        chk("t1_rsp_y", ry, 25'h00054B9);
        chk("t1_id", rid, 0);
        chk("t1_stall", rst_l, 0);
        tick();

        // 3: hold 0 acts as 1
        serve(1, 5'b00111, 4'd0, ap, lt, ry, rid, rst_l);
        chk("t3_applies", ap, 1);
        chk("t3_latency", lt, 2);
        chk("t3_rsp_y", ry, 25'h00074A7);
        chk("t3_id", rid, 1);
        tick();

        // 2: both valid after reset -> host, BIST, host, BIST
        do_reset();
        req0_valid = 1; req0_x = 5'd1; req0_hold = 4'd1;
        req1_valid = 1; req1_x = 5'd2; req1_hold = 4'd1;
        for (int i = 0; i < 40 && gl.size() < 4; i++) begin
            @(negedge clk);
            if (req0_ready) gl.push_back(1'b0);
            if (req1_ready) gl.push_back(1'b1);
            tick();
        end
        chk("t2_grants", gl.size(), 4);
        for (int i = 0; i < gl.size(); i++) chk("t2_order", gl[i], (i % 2));
        req0_valid = 0; req1_valid = 0;
        repeat (6) tick();

        // 5: back-pressure on the response channel
        rsp_ready = 0;
        serve(0, 5'b01010, 4'd2, ap, lt, ry0, rid, rst_l);
        req1_valid = 1; req1_x = 5'd9; req1_hold = 4'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk("t5_valid_held", rsp_valid, 1);
            chk("t5_y_stable", rsp_y, ry0);
            chk("t5_no_ready", req1_ready, 0);
        end
        tick(); rsp_ready = 1;
        tick();
        @(negedge clk);
        chk("t5_next_grant", req1_ready, 1);
        tick(); req1_valid = 0;
        repeat (6) tick();

        // 4: frozen outputs trip the watchdog
        trap = 1; rsp_ready = 0;
        serve(0, 5'b00011, 4'd15, ap, lt, ry, rid, rst_l);
        chk("t4_applies", ap, 9);
        chk("t4_latency", lt, 10);
        chk("t4_stall", rst_l, 1);
        chk("t4_rsp_y", ry, TRAP_Y);
        chk("t4_flag", stall_flag, 1);
        tick(); rsp_ready = 1;
        tick(); req0_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_locked_ready", req0_ready, 0);
            chk("t4_locked_flag", stall_flag, 1);
            tick();
        end
        req0_valid = 0; stall_clr = 1; trap = 0;
        tick(); stall_clr = 0;
        @(negedge clk);
        chk("t4_flag_clear", stall_flag, 0);
        tick();
        serve(0, 5'b10000, 4'd2, ap, lt, ry, rid, rst_l);
        chk("t4_after_applies", ap, 2);
        chk("t4_after_stall", rst_l, 0);
        tick();

        // 6: reset in the middle of an apply burst
        req0_valid = 1; req0_x = 5'd3; req0_hold = 4'd10;
        @(negedge clk);
        tick(); req0_valid = 0;
        tick(); tick();
        rst = 1;
        @(negedge clk);
        chk("t6_apply", dut_apply, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_rsp_y", rsp_y, 0);
        tick(); rst = 0;
        serve(1, 5'b10101, 4'd2, ap, lt, ry, rid, rst_l);
        chk("t6_applies", ap, 2);
        chk("t6_rsp_y", ry, 25'h00034B5);
        chk("t6_id", rid, 1);
        tick();

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            tick();
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_x     = XW'($urandom);
            req1_x     = XW'($urandom);
            req0_hold  = ($urandom_range(0, 3) == 0) ? HOLDW'($urandom) : HOLDW'($urandom_range(0, 3));
            req1_hold  = ($urandom_range(0, 3) == 0) ? HOLDW'($urandom) : HOLDW'($urandom_range(0, 3));
            rsp_ready  = ($urandom_range(0, 3) != 0);
            stall_clr  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 40) == 0) trap = ~trap;
        end
        tick();
        req0_valid = 0; req1_valid = 0; rsp_ready = 1; stall_clr = 1; trap = 0;
        repeat (40) tick();
        got = (n_tests > 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
